// File: rtl/grayscale_pack.sv
// RGBA-to-gray packer: converts 16-pixel RGBA blocks to gray bytes and packs
// four of them into one 64-byte output block, with early flush on in_last.
module grayscale_pack (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         out_last,
    output logic [31:0]  out_count,
    output logic         done
);

    typedef enum logic [1:0] {S_PK_IDLE, S_PK_FILL, S_PK_DONE} state_t;

    state_t         r_state, w_next;
    logic   [1:0]   r_slot;
    logic   [383:0] r_pack;
    logic   [511:0] r_out_data;
    logic           r_out_valid;
    logic           r_out_last;
    logic   [31:0]  r_count;
    logic           r_rdy_en;

    logic   [127:0] w_gray;
    logic   [383:0] w_pack_nxt;
    logic   [511:0] w_full;
    logic           w_acc, w_cmpl, w_oacc;

    for (genvar i = 0; i < 16; i++) begin : g_px
        logic [15:0] w_sum;
        assign w_sum = 16'd77  * {8'd0, in_data[32*i +: 8]}
                     + 16'd150 * {8'd0, in_data[32*i + 8 +: 8]}
                     + 16'd29  * {8'd0, in_data[32*i + 16 +: 8]};
        assign w_gray[8*i +: 8] = w_sum[15:8];
    end

    // The pack buffer is zeroed after every issue, so slots above the
    // completing one are already zero when a group is flushed early.
    always_comb begin
        w_pack_nxt = r_pack;
        case (r_slot)
            2'd0:    w_pack_nxt[127:0]   = w_gray;
            2'd1:    w_pack_nxt[255:128] = w_gray;
            2'd2:    w_pack_nxt[383:256] = w_gray;
            default: ;
        endcase
        w_full = {(r_slot == 2'd3) ? w_gray : 128'd0, w_pack_nxt};
    end

    assign in_ready = r_rdy_en && !clear && (r_state != S_PK_DONE)
                   && (!r_out_valid || out_ready);
    assign w_acc    = in_valid && in_ready;
    assign w_cmpl   = w_acc && (in_last || (r_slot == 2'd3));
    assign w_oacc   = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdy_en <= 1'b0;
        else        r_rdy_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot      <= 2'd0;
            r_pack      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_count     <= 32'd0;
        end else if (clear) begin
            r_slot      <= 2'd0;
            r_pack      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_count     <= 32'd0;
        end else begin
            if (w_oacc) r_count <= r_count + 32'd1;
            // A completing accept reloads the output even while the old block
            // is being taken, so back-to-back outputs have no bubble.
            if (w_cmpl) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_full;
                r_out_last  <= in_last;
                r_pack      <= '0;
                r_slot      <= 2'd0;
            end else begin
                if (w_oacc) r_out_valid <= 1'b0;
                if (w_acc) begin
                    r_pack <= w_pack_nxt;
                    r_slot <= r_slot + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_PK_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PK_IDLE: if (w_acc) w_next = S_PK_FILL;
            S_PK_FILL: if (w_oacc && r_out_last) w_next = S_PK_DONE;
            S_PK_DONE: ;
            default:   w_next = S_PK_IDLE;
        endcase
        if (clear) w_next = S_PK_IDLE;
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_count = r_count;
    assign done      = (r_state == S_PK_DONE);

endmodule
